// File: rtl/fft_frame_buffer_if.sv
// Sample/frame bus between the audio receiver, the frame buffer and FFT control.
// The master drives samples and acks; the slave (frame buffer) presents the held frame.
interface fft_frame_buffer_if #(
    parameter int WIDTH = 24
);
    logic signed [WIDTH-1:0] sample_in;
    logic                    sample_valid;
    logic                    frame_ack;
    logic signed [WIDTH-1:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic signed [WIDTH-1:0] s8, s9, s10, s11, s12, s13, s14, s15;
    logic                    frame_valid;
    logic [4:0]              fill_level;
    logic [7:0]              overflow_count;

    modport master (
        output sample_in, sample_valid, frame_ack,
        input  s0, s1, s2, s3, s4, s5, s6, s7,
        input  s8, s9, s10, s11, s12, s13, s14, s15,
        input  frame_valid, fill_level, overflow_count
    );

    modport slave (
        input  sample_in, sample_valid, frame_ack,
        output s0, s1, s2, s3, s4, s5, s6, s7,
        output s8, s9, s10, s11, s12, s13, s14, s15,
        output frame_valid, fill_level, overflow_count
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// Double-buffered 16-sample frame collector with decimation feeding the FFT.
// One bank fills from the serial sample stream while the other holds a stable
// frame for the FFT until it is acknowledged; frames that complete while the
// hold bank is still occupied are dropped and counted.
module fft_frame_buffer #(
    parameter int WIDTH = 24,
    parameter int DECIM = 1
) (
    input logic          Clk,
    input logic          Reset,
    fft_frame_buffer_if.slave bus
);
    localparam logic [7:0] DCNT_LAST = 8'(DECIM - 1);

    logic signed [WIDTH-1:0] fill_bank [16];
    logic signed [WIDTH-1:0] hold_bank [16];
    logic [4:0]              fill_cnt;
    logic [7:0]              dcnt;
    logic                    held_valid;
    logic [7:0]              ovf_cnt;

    logic accept;
    logic complete;
    logic hold_free;

    // A sample is taken only on the first valid of each decimation period;
    // the 16th accepted sample completes a frame, which may move to the hold
    // bank if that bank is empty or being acknowledged in the same cycle.
    always_comb begin
        accept    = bus.sample_valid && (dcnt == 8'd0);
        complete  = accept && (fill_cnt == 5'd15);
        hold_free = !held_valid || bus.frame_ack;
    end

    // Decimation counter: counts every valid sample modulo DECIM.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            dcnt <= 8'd0;
        end else if (bus.sample_valid) begin
            dcnt <= (dcnt == DCNT_LAST) ? 8'd0 : dcnt + 8'd1;
        end
    end

    // Fill bank: store each accepted sample at the current slot, restart at
    // slot 0 once a frame completes whether it was transferred or dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fill_cnt <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                fill_bank[i] <= '0;
            end
        end else if (accept) begin
            fill_bank[fill_cnt[3:0]] <= bus.sample_in;
            fill_cnt                 <= complete ? 5'd0 : fill_cnt + 5'd1;
        end
    end

    // Hold bank: load the completed frame (newest sample taken straight from
    // the input) only when free; otherwise the contents never change.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                hold_bank[i] <= '0;
            end
        end else if (complete && hold_free) begin
            for (int i = 0; i < 15; i++) begin
                hold_bank[i] <= fill_bank[i];
            end
            hold_bank[15] <= bus.sample_in;
        end
    end

    // Frame-valid flag and saturating drop counter; a transfer wins over an
    // ack so a simultaneous ack/completion leaves the flag set.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            held_valid <= 1'b0;
            ovf_cnt    <= 8'd0;
        end else if (complete && hold_free) begin
            held_valid <= 1'b1;
        end else if (complete) begin
            if (ovf_cnt != 8'd255) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end else if (bus.frame_ack) begin
            held_valid <= 1'b0;
        end
    end

    // Present the hold bank and status on the bus.
    always_comb begin
        bus.s0             = hold_bank[0];
        bus.s1             = hold_bank[1];
        bus.s2             = hold_bank[2];
        bus.s3             = hold_bank[3];
        bus.s4             = hold_bank[4];
        bus.s5             = hold_bank[5];
        bus.s6             = hold_bank[6];
        bus.s7             = hold_bank[7];
        bus.s8             = hold_bank[8];
        bus.s9             = hold_bank[9];
        bus.s10            = hold_bank[10];
        bus.s11            = hold_bank[11];
        bus.s12            = hold_bank[12];
        bus.s13            = hold_bank[13];
        bus.s14            = hold_bank[14];
        bus.s15            = hold_bank[15];
        bus.frame_valid    = held_valid;
        bus.fill_level     = fill_cnt;
        bus.overflow_count = ovf_cnt;
    end
endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Upstream neighbour of FastFourierTransform in the audio visualizer.
- Collects serial 24-bit audio samples from the audio receiver into 16-sample frames and decimates them by a parameter.
- Double-buffered: one bank fills while the other is held stable on s0..s15 for the FFT.
- Uses a valid/ack handshake and counts frames dropped on overflow.

Parameters:
- WIDTH, 24, sample width in bits; must match FFT input width.
- DECIM, 1, sample decimation factor: accept every DECIM-th valid sample (1 = accept all); legal range 1..255.

Ports:
- Clk  input  1  system clock (50 MHz); all logic on rising edge.
- Reset  input  1  synchronous, active-low reset; Reset==0 at a rising edge resets all state.
- sample_in  input  WIDTH  signed audio sample; qualified by sample_valid.
- sample_valid  input  1  one-cycle strobe per incoming audio sample.
- frame_ack  input  1  consumer (FFT control) has latched the held frame; releases the hold bank.
- s0..s15  output  WIDTH each  held frame; s0 = oldest accepted sample, s15 = newest; feed FFT s0..s15 directly.
- frame_valid  output  1  held frame on s0..s15 is new and unconsumed.
- fill_level  output  5  samples currently in the fill bank, 0..15.
- overflow_count  output  8  frames dropped because the hold bank was still occupied; saturates at 255.

Behaviour:
- Reset (Reset==0 at edge):
  - s0..s15 = 0, frame_valid = 0, fill_level = 0, overflow_count = 0, decimation counter = 0.
  - Takes priority over every other input; sample_valid and frame_ack are ignored that cycle.
  - Reset mid-frame discards the partial fill and any held frame.
- Decimation:
  - An 8-bit counter dcnt advances on each sample_valid.
  - A sample is accepted when sample_valid=1 and dcnt==0; dcnt then becomes (dcnt+1) mod DECIM.
  - With DECIM=1 every valid sample is accepted.
- Fill bank:
  - An accepted sample is written to slot fill_level, then fill_level increments.
  - fill_level wraps from 15 to 0 when the 16th sample completes a frame.
  - Samples are stored unmodified, with no arithmetic.
- Frame completion (16th accepted sample at edge t):
  - If the hold bank is free at edge t, the fill bank is copied to s0..s15 and frame_valid=1 is visible after edge t, i.e. one cycle after the 16th sample is presented.
  - The hold bank is free when frame_valid==0, or when frame_ack==1 in the same cycle (simultaneous ack and completion: the transfer succeeds and frame_valid stays 1).
  - Otherwise the completed frame is dropped: s0..s15 are unchanged, overflow_count increments (saturating), and filling restarts at slot 0.
- Hold bank:
  - s0..s15 are stable whenever frame_valid==1 and change only on a transfer.
  - frame_ack with no completing frame clears frame_valid on the next edge; s0..s15 keep their values.
  - frame_ack while frame_valid==0 has no effect.
- Fill bank state machine (implicit in fill_level):
  - FILLING (0..14) -> COMPLETE on accepted sample at 15 -> transfer or drop -> FILLING(0), all in one edge.
  - No idle state; the fill bank is always collecting.
- Back-to-back frames are supported: a new sample may be accepted on the very edge a frame transfers.
- Throughput limit: every accepted sample is captured with no stall; backpressure is expressed only through drops counted by overflow_count.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with sample_valid toggling -> all outputs 0; fill_level stays 0.
- Basic frame, DECIM=1: feed values 1..16 on consecutive cycles, then raise frame_ack 3 cycles later -> frame_valid rises exactly one cycle after value 16 with s0=1 and s15=16; it clears one cycle after the ack, while s0..s15 keep their values.
- Decimation, DECIM=3: feed values 0..47 -> frame holds s0=0, s1=3, ..., s15=45; frame_valid rises the cycle after value 45.
- Overflow: two full frames (1..16, then 17..32) with no ack -> s0..s15 still hold 1..16, overflow_count=1; a third unacked frame -> overflow_count=2; 300 unacked frames -> count saturates at 255.
- Simultaneous: frame_ack asserted on the same cycle as the 16th sample of frame 2 -> s0..s15 = frame 2, frame_valid stays 1, overflow_count unchanged.
- Reset mid-operation: Reset=0 at fill_level=9 with frame_valid=1 -> all outputs 0 next cycle; a following full frame of 16 samples transfers normally.
